// File: rtl/data_memory_responder.sv
// -----------------------------------------------------------------------------
// data_memory_responder
//
// Memory-side responder for the processor's data-memory port. A byte-wide RAM
// of 2**DEPTH_W entries answers the processor (DRAM_addr / DRAM_data_write /
// write -> data_in). The block also sequences a job:
//   IDLE -> LOAD (host streams the input image into RAM starting at address 0)
//        -> RUN  (processor enabled)
//        -> DUMP (results stream out from dump_base) -> IDLE
//
// Ports
//   clk, rst_n          clock, synchronous active-low reset
//   DRAM_addr           processor address; low DEPTH_W bits index the RAM
//   DRAM_data_write     processor write data
//   write               processor write strobe (honoured only in RUN)
//   data_in             registered read data, mem[DRAM_addr] one cycle later
//   enable              processor enable, high only in RUN
//   finish              processor done (level or pulse), sampled in RUN
//   load_start          starts a job in IDLE; samples load_len and dump_len
//   load_len/dump_len   byte counts, DEPTH_W+1 bits so full depth is legal
//   host_valid/_data/_ready    LOAD byte stream (valid/ready)
//   dump_base           first dump address, sampled on entering DUMP
//   dump_valid/_data/_ready    DUMP byte stream (valid/ready)
//   busy                high whenever the job is not IDLE
//   addr_err            sticky out-of-range flag
//
// Configuration macro: DRAM_RANGE_CHECK_EN
//   defined   : a RUN access with nonzero DRAM_addr[ADDR_W-1:DEPTH_W] drops the
//               write, returns 0 on data_in and sets addr_err (cleared by reset
//               or an accepted load_start).
//   undefined : upper address bits are ignored (aliasing), addr_err is 0.
// -----------------------------------------------------------------------------
module data_memory_responder #(
    parameter int DEPTH_W = 16,
    parameter int ADDR_W  = 24,
    parameter int DATA_W  = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [ADDR_W-1:0]  DRAM_addr,
    input  logic [DATA_W-1:0]  DRAM_data_write,
    input  logic               write,
    output logic [DATA_W-1:0]  data_in,
    output logic               enable,
    input  logic               finish,
    input  logic               load_start,
    input  logic [DEPTH_W:0]   load_len,
    input  logic               host_valid,
    input  logic [DATA_W-1:0]  host_data,
    output logic               host_ready,
    input  logic [DEPTH_W-1:0] dump_base,
    input  logic [DEPTH_W:0]   dump_len,
    output logic               dump_valid,
    output logic [DATA_W-1:0]  dump_data,
    input  logic               dump_ready,
    output logic               busy,
    output logic               addr_err
);

    localparam int MEM_DEPTH = 1 << DEPTH_W;

    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_RUN, ST_DUMP} state_t;

    state_t             state_reg, state_next;
    logic [DEPTH_W:0]   load_len_reg, dump_len_reg;
    logic [DEPTH_W:0]   wcnt_reg;       // bytes accepted in LOAD
    logic [DEPTH_W:0]   iss_cnt_reg;    // dump reads issued to the RAM
    logic [DEPTH_W:0]   xfer_cnt_reg;   // dump bytes handed to the host
    logic [DEPTH_W-1:0] raddr_reg;      // dump read address, wraps naturally
    logic               dump_valid_reg;
    logic               enable_reg;
    logic [DATA_W-1:0]  data_in_reg;
    logic [DATA_W-1:0]  dump_data_reg;

    logic [DATA_W-1:0]  mem [MEM_DEPTH];

    logic [DEPTH_W-1:0] proc_addr;
    logic               proc_oor;
    logic               host_xfer, dump_xfer, dump_issue, proc_we;
    logic               mem_we;
    logic [DEPTH_W-1:0] mem_waddr;
    logic [DATA_W-1:0]  mem_wdata;

    assign proc_addr = DRAM_addr[DEPTH_W-1:0];

`ifdef DRAM_RANGE_CHECK_EN
    assign proc_oor = (state_reg == ST_RUN) && (DRAM_addr[ADDR_W-1:DEPTH_W] != '0);
`else
    logic unused_upper_addr;
    assign unused_upper_addr = ^DRAM_addr[ADDR_W-1:DEPTH_W];
    assign proc_oor = 1'b0;
`endif

    // host_ready drops once the requested count is reached so a zero-length
    // load can never write a stray byte during its single LOAD cycle.
    assign host_ready = (state_reg == ST_LOAD) && (wcnt_reg != load_len_reg);
    assign host_xfer  = host_ready && host_valid;
    assign proc_we    = (state_reg == ST_RUN) && write && !proc_oor;

    // The RAM output register doubles as the one-entry dump holding register:
    // a new read is issued only when the current byte is absent or leaving.
    assign dump_xfer  = dump_valid_reg && dump_ready;
    assign dump_issue = (state_reg == ST_DUMP) && (iss_cnt_reg != dump_len_reg) &&
                        (!dump_valid_reg || dump_ready);

    // LOAD and RUN are exclusive, so one write port serves both. Writes are
    // blocked on a reset edge so an abort never lands a final byte.
    assign mem_we    = rst_n && (host_xfer || proc_we);
    assign mem_waddr = (state_reg == ST_LOAD) ? wcnt_reg[DEPTH_W-1:0] : proc_addr;
    assign mem_wdata = (state_reg == ST_LOAD) ? host_data : DRAM_data_write;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (load_start) state_next = ST_LOAD;
            ST_LOAD: begin
                if (wcnt_reg == load_len_reg)
                    state_next = ST_RUN;
                else if (host_xfer && (wcnt_reg + 1'b1 == load_len_reg))
                    state_next = ST_RUN;
            end
            ST_RUN:  if (finish) state_next = ST_DUMP;
            ST_DUMP: begin
                if (xfer_cnt_reg == dump_len_reg)
                    state_next = ST_IDLE;
                else if (dump_xfer && (xfer_cnt_reg + 1'b1 == dump_len_reg))
                    state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg      <= ST_IDLE;
            enable_reg     <= 1'b0;
            dump_valid_reg <= 1'b0;
            load_len_reg   <= '0;
            dump_len_reg   <= '0;
            wcnt_reg       <= '0;
            iss_cnt_reg    <= '0;
            xfer_cnt_reg   <= '0;
            raddr_reg      <= '0;
        end else begin
            state_reg  <= state_next;
            enable_reg <= (state_next == ST_RUN);

            if ((state_reg == ST_IDLE) && load_start) begin
                load_len_reg <= load_len;
                dump_len_reg <= dump_len;
                wcnt_reg     <= '0;
            end else if (host_xfer) begin
                wcnt_reg <= wcnt_reg + 1'b1;
            end

            if ((state_reg == ST_RUN) && finish) begin
                raddr_reg    <= dump_base;
                iss_cnt_reg  <= '0;
                xfer_cnt_reg <= '0;
            end else begin
                if (dump_issue) begin
                    raddr_reg   <= raddr_reg + 1'b1;
                    iss_cnt_reg <= iss_cnt_reg + 1'b1;
                end
                if (dump_xfer)
                    xfer_cnt_reg <= xfer_cnt_reg + 1'b1;
            end

            if (dump_issue)
                dump_valid_reg <= 1'b1;
            else if (dump_xfer)
                dump_valid_reg <= 1'b0;
        end
    end

    // RAM write port
    always_ff @(posedge clk) begin
        if (mem_we)
            mem[mem_waddr] <= mem_wdata;
    end

    // Processor read port: read-before-write, tracks DRAM_addr in every state.
    always_ff @(posedge clk) begin
        if (!rst_n)
            data_in_reg <= '0;
        else if (proc_oor)
            data_in_reg <= '0;
        else
            data_in_reg <= mem[proc_addr];
    end

    // Dump read port with read enable; holds its byte until accepted.
    always_ff @(posedge clk) begin
        if (dump_issue)
            dump_data_reg <= mem[raddr_reg];
    end

`ifdef DRAM_RANGE_CHECK_EN
    logic addr_err_reg;
    always_ff @(posedge clk) begin
        if (!rst_n)
            addr_err_reg <= 1'b0;
        else if ((state_reg == ST_IDLE) && load_start)
            addr_err_reg <= 1'b0;
        else if (proc_oor)
            addr_err_reg <= 1'b1;
    end
    assign addr_err = addr_err_reg;
`else
    assign addr_err = 1'b0;
`endif

    assign data_in    = data_in_reg;
    assign enable     = enable_reg;
    assign dump_valid = dump_valid_reg;
    assign dump_data  = dump_data_reg;
    assign busy       = (state_reg != ST_IDLE);

endmodule
